// File: rtl/native_port_arbiter.sv
// Two-to-one arbiter for the controller's native user port: round-robin command grant
// with packet lock, write data steered by a write-owner FIFO, read data by a read-owner FIFO.
module native_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [1:0]              s_cmd_valid,
  output logic [1:0]              s_cmd_ready,
  input  logic [1:0]              s_cmd_last,
  input  logic [1:0]              s_cmd_we,
  input  logic [2*ADDR_W-1:0]     s_cmd_addr,
  input  logic [1:0]              s_wdata_valid,
  output logic [1:0]              s_wdata_ready,
  input  logic [2*DATA_W-1:0]     s_wdata_data,
  input  logic [2*DATA_W/8-1:0]   s_wdata_we,
  output logic [1:0]              s_rdata_valid,
  input  logic [1:0]              s_rdata_ready,
  output logic [DATA_W-1:0]       s_rdata_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  output logic                    m_cmd_last,
  output logic                    m_cmd_we,
  output logic [ADDR_W-1:0]       m_cmd_addr,
  output logic                    m_wdata_valid,
  input  logic                    m_wdata_ready,
  output logic [DATA_W-1:0]       m_wdata_data,
  output logic [DATA_W/8-1:0]     m_wdata_we,
  input  logic                    m_rdata_valid,
  output logic                    m_rdata_ready,
  input  logic [DATA_W-1:0]       m_rdata_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int MW = DATA_W / 8;

  typedef logic [PW:0] ptr_t;

  localparam ptr_t PTR_ONE  = {{PW{1'b0}}, 1'b1};
  localparam ptr_t PTR_ZERO = {(PW+1){1'b0}};

  function automatic logic fifo_full(input ptr_t wp, input ptr_t rp);
    return (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  endfunction

  function automatic logic fifo_empty(input ptr_t wp, input ptr_t rp);
    return wp == rp;
  endfunction

  logic                  lock_r;
  logic                  gnt_r;
  logic                  last_served_r;
  logic [FIFO_DEPTH-1:0] wr_fifo_r;
  logic [FIFO_DEPTH-1:0] rd_fifo_r;
  ptr_t                  wr_wptr_r;
  ptr_t                  wr_rptr_r;
  ptr_t                  rd_wptr_r;
  ptr_t                  rd_rptr_r;

  logic sel_s;
  logic space_s;
  logic cmd_valid_s;
  logic cmd_acc_s;
  logic wr_full_s;
  logic wr_empty_s;
  logic rd_full_s;
  logic rd_empty_s;
  logic wr_push_s;
  logic wr_pop_s;
  logic rd_push_s;
  logic rd_pop_s;
  logic wr_head_s;
  logic rd_head_s;

  assign wr_full_s  = fifo_full(wr_wptr_r, wr_rptr_r);
  assign wr_empty_s = fifo_empty(wr_wptr_r, wr_rptr_r);
  assign rd_full_s  = fifo_full(rd_wptr_r, rd_rptr_r);
  assign rd_empty_s = fifo_empty(rd_wptr_r, rd_rptr_r);
  assign wr_head_s  = wr_fifo_r[wr_rptr_r[PW-1:0]];
  assign rd_head_s  = rd_fifo_r[rd_rptr_r[PW-1:0]];

  // Grant selection: locked owner, else the lone requester, else round-robin.
  always_comb begin
    sel_s = ~last_served_r;
    if (lock_r) begin
      sel_s = gnt_r;
    end else if (s_cmd_valid == 2'b01) begin
      sel_s = 1'b0;
    end else if (s_cmd_valid == 2'b10) begin
      sel_s = 1'b1;
    end else begin
      sel_s = ~last_served_r;
    end
  end

  assign space_s     = s_cmd_we[sel_s] ? !wr_full_s : !rd_full_s;
  assign cmd_valid_s = s_cmd_valid[sel_s] & space_s;
  assign cmd_acc_s   = cmd_valid_s & m_cmd_ready;
  assign wr_push_s   = cmd_acc_s & s_cmd_we[sel_s];
  assign rd_push_s   = cmd_acc_s & ~s_cmd_we[sel_s];

  // Command handshakes are masked while reset is held so both sides look idle.
  assign m_cmd_valid = cmd_valid_s & sys_rst;
  assign m_cmd_last  = s_cmd_last[sel_s];
  assign m_cmd_we    = s_cmd_we[sel_s];
  assign m_cmd_addr  = sel_s ? s_cmd_addr[2*ADDR_W-1:ADDR_W] : s_cmd_addr[ADDR_W-1:0];

  // Only the selected requester ever sees command ready.
  always_comb begin
    s_cmd_ready = 2'b00;
    if (sys_rst) begin
      s_cmd_ready[sel_s] = m_cmd_ready & space_s;
    end else begin
      s_cmd_ready = 2'b00;
    end
  end

  assign m_wdata_valid = !wr_empty_s & s_wdata_valid[wr_head_s];
  assign m_wdata_data  = wr_head_s ? s_wdata_data[2*DATA_W-1:DATA_W] : s_wdata_data[DATA_W-1:0];
  assign m_wdata_we    = wr_head_s ? s_wdata_we[2*MW-1:MW] : s_wdata_we[MW-1:0];
  assign wr_pop_s      = m_wdata_valid & m_wdata_ready;

  // Write-data ready goes only to the owner of the oldest outstanding write.
  always_comb begin
    s_wdata_ready = 2'b00;
    if (!wr_empty_s) begin
      s_wdata_ready[wr_head_s] = m_wdata_ready;
    end else begin
      s_wdata_ready = 2'b00;
    end
  end

  assign m_rdata_ready = !rd_empty_s & s_rdata_ready[rd_head_s];
  assign s_rdata_data  = m_rdata_data;
  assign rd_pop_s      = m_rdata_valid & m_rdata_ready;

  // Read data is routed to the owner of the oldest outstanding read, never when none is pending.
  always_comb begin
    s_rdata_valid = 2'b00;
    if (!rd_empty_s) begin
      s_rdata_valid[rd_head_s] = m_rdata_valid;
    end else begin
      s_rdata_valid = 2'b00;
    end
  end

  // Arbitration state: lock holds a stalled or mid-packet grant; last beat releases it.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      lock_r        <= 1'b0;
      gnt_r         <= 1'b0;
      last_served_r <= 1'b1;
    end else if (cmd_valid_s && !m_cmd_ready) begin
      lock_r <= 1'b1;
      gnt_r  <= sel_s;
    end else if (cmd_acc_s && !s_cmd_last[sel_s]) begin
      lock_r <= 1'b1;
      gnt_r  <= sel_s;
    end else if (cmd_acc_s) begin
      lock_r        <= 1'b0;
      last_served_r <= sel_s;
    end else begin
      lock_r        <= lock_r;
      gnt_r         <= gnt_r;
      last_served_r <= last_served_r;
    end
  end

  // Owner FIFOs; a push into a full FIFO cannot happen because space_s already gates it.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_fifo_r <= {FIFO_DEPTH{1'b0}};
      rd_fifo_r <= {FIFO_DEPTH{1'b0}};
      wr_wptr_r <= PTR_ZERO;
      wr_rptr_r <= PTR_ZERO;
      rd_wptr_r <= PTR_ZERO;
      rd_rptr_r <= PTR_ZERO;
    end else begin
      if (wr_push_s) begin
        wr_fifo_r[wr_wptr_r[PW-1:0]] <= sel_s;
        wr_wptr_r                    <= wr_wptr_r + PTR_ONE;
      end else begin
        wr_wptr_r <= wr_wptr_r;
      end
      if (wr_pop_s) begin
        wr_rptr_r <= wr_rptr_r + PTR_ONE;
      end else begin
        wr_rptr_r <= wr_rptr_r;
      end
      if (rd_push_s) begin
        rd_fifo_r[rd_wptr_r[PW-1:0]] <= sel_s;
        rd_wptr_r                    <= rd_wptr_r + PTR_ONE;
      end else begin
        rd_wptr_r <= rd_wptr_r;
      end
      if (rd_pop_s) begin
        rd_rptr_r <= rd_rptr_r + PTR_ONE;
      end else begin
        rd_rptr_r <= rd_rptr_r;
      end
    end
  end

endmodule

// File: doc/native_port_arbiter.md
# native_port_arbiter

Two-to-one arbiter that shares the controller's single native user port (cmd / wdata / rdata) between two native-port requesters, such as the AXI front-end and the Wishbone front-end. Commands are granted round-robin, with the grant locked for multi-beat packets. Write data is steered by a FIFO of granted write-command owners, and read data is returned through a FIFO of read-command owners. One cmd beat corresponds to exactly one wdata beat (write) or one rdata beat (read).

## Interface
- ADDR_W, 32, native command address width
- DATA_W, 256, data width; mask width is DATA_W/8
- FIFO_DEPTH, 8, entries in each owner FIFO; power of 2, at least 2
- sys_clk  in  1  sole clock, rising edge
- sys_rst  in  1  asynchronous, active-low reset
- s_cmd_valid  in  2  per-port command valid; bit i is port i
- s_cmd_ready  out  2  per-port command ready
- s_cmd_last  in  2  last beat of a locked command packet
- s_cmd_we  in  2  1 = write, 0 = read
- s_cmd_addr  in  2*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
- s_wdata_valid  in  2  per-port write-data valid
- s_wdata_ready  out  2  per-port write-data ready
- s_wdata_data  in  2*DATA_W  packed per port
- s_wdata_we  in  2*DATA_W/8  packed byte enables
- s_rdata_valid  out  2  per-port read-data valid
- s_rdata_ready  in  2  per-port read-data ready
- s_rdata_data  out  DATA_W  broadcast copy of m_rdata_data
- m_cmd_valid / m_cmd_ready  out / in  1  controller command handshake
- m_cmd_last  out  1  last flag of the granted port
- m_cmd_we  out  1  we of the granted port
- m_cmd_addr  out  ADDR_W  address of the granted port
- m_wdata_valid / m_wdata_ready  out / in  1  controller write-data handshake
- m_wdata_data  out  DATA_W  write data of the port at the head of the write-owner FIFO
- m_wdata_we  out  DATA_W/8  byte enables of the port at the head of the write-owner FIFO
- m_rdata_valid / m_rdata_ready  in / out  1  controller read-data handshake
- m_rdata_data  in  DATA_W  read data from the controller

## Operation
- State registers:
  - lock, 1 bit
  - gnt, 1 bit (locked owner)
  - last_served, 1 bit
  - wr_fifo and rd_fifo, FIFO_DEPTH x 1-bit owner IDs; pointers are log2(FIFO_DEPTH)+1 bits wide and full/empty are derived from pointer MSB compare.
- Port selection (sel):
  - If lock = 1, sel = gnt.
  - Otherwise, if exactly one port is valid, sel = that port.
  - If both ports are valid, sel = ~last_served.
  - If neither is valid, sel = ~last_served (don't-care).
- space = s_cmd_we[sel] ? !wr_full : !rd_full.
- Command outputs:
  - m_cmd_valid = s_cmd_valid[sel] & space.
  - s_cmd_ready[sel] = m_cmd_ready & space; the other bit is 0.
  - m_cmd_last, m_cmd_we and m_cmd_addr are muxed from sel.
- Accept is m_cmd_valid & m_cmd_ready. On accept, push sel into wr_fifo if we = 1, otherwise into rd_fifo.
- Lock control:
  - Set lock and load gnt = sel when m_cmd_valid & !m_cmd_ready (stall hold: the selected command stays stable), or when the accepted beat has last = 0.
  - Clear lock and set last_served = sel when the accepted beat has last = 1.
- Write path:
  - h = wr_fifo head.
  - m_wdata_valid = !wr_empty & s_wdata_valid[h].
  - s_wdata_ready[h] = !wr_empty & m_wdata_ready.
  - Data and mask are muxed by h.
  - Pop on the m_wdata handshake.
- Read path:
  - r = rd_fifo head.
  - s_rdata_valid[r] = m_rdata_valid & !rd_empty.
  - m_rdata_ready = !rd_empty & s_rdata_ready[r].
  - Pop on the rdata handshake.
- Boundary conditions:
  - FIFO full: a push is blocked even if a pop happens in the same cycle. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - If m_rdata_valid arrives while rd_empty, m_rdata_ready stays 0 and nothing is routed. This is a bench-checked protocol error.
  - A port whose wdata is not at the FIFO head sees ready = 0, even if it is valid.
  - Reset mid-packet drops lock and all FIFO contents. The controller is reset together with this block.

## Timing
- Command path is combinational: 0-cycle latency from s_cmd to m_cmd.
- A write command accepted at cycle t allows its wdata beat to pass at t+1 at the earliest (FIFO write is registered). Wdata presented earlier waits.
- Read data for a command accepted at t can be routed at t+1 at the earliest.
- Reset state while sys_rst = 0:
  - lock = 0, gnt = 0, last_served = 1 (port 0 wins first), FIFOs empty.
  - Outputs: s_cmd_ready = 0, s_wdata_ready = 0, s_rdata_valid = 0, m_cmd_valid = 0, m_wdata_valid = 0, m_rdata_ready = 0.
  - Data outputs follow their muxes.
- Full throughput is one cmd, one wdata and one rdata per cycle, concurrently.

## Test plan
- Both ports issue single-beat reads (last = 1) continuously, with m_cmd_ready = 1 -> grants alternate 0, 1, 0, 1 starting with port 0. The rdata beats returned (A, B, C, D) arrive in order at ports 0, 1, 0, 1.
- Port 1 sends a 4-beat write packet (last on beat 4) while port 0 requests a read -> all 4 port-1 beats are accepted back-to-back, and port 0 is granted on the next cycle. Port 1's wdata passes 4 beats, then port 0's read routes.
- m_cmd_ready is held 0 for 3 cycles while both ports are valid -> sel, addr and we stay stable on m_cmd. No swap occurs until accept.
- 8 writes are issued with m_wdata_ready = 0 -> the 9th write is blocked (s_cmd_ready = 0) while reads are still accepted. One wdata pop lets the 9th write pass the following cycle.
- Port 0 wdata is valid before its cmd -> s_wdata_ready[0] stays 0 until the cycle after cmd accept, then the handshake completes.
- Reset asserted mid-packet with FIFOs holding 3 entries -> all outputs go to 0 immediately. After release, port 0 wins the first simultaneous request.
